prog_updown_counter: RTL and testbench

//   Parametrised synchronous up/down modulo counter; successor to the 4-bit ripple counter.

---
 rtl/prog_updown_counter_pkg.sv | 22 ++
 rtl/cnt_limit_detect.sv | 56 +++++
 rtl/prog_updown_counter.sv | 86 ++++++++
 tb/tb_prog_updown_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/prog_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cnt_pkg
// Description : Shared mode constants and load clamping for the up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Widened to 33 bits so a 32-bit counter with MODULUS == 2**32 still fits.
    function automatic logic [32:0] clamp_load(input logic [32:0] val,
                                               input logic [32:0] modulus);
        if (val < modulus) begin
            return val;
        end
        return modulus - 33'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_limit_detect.sv
`default_nettype none
// ============================================================================
// Module      : cnt_limit_detect
// Description : Combinational limit detection and next-count computation.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_limit_detect
    import cnt_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    output logic             at_limit,
    output logic [WIDTH-1:0] next_q
);

    localparam logic [WIDTH:0] c_top = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_sum;
    logic           w_unused_msb;

    // One extra bit keeps MODULUS == 2**WIDTH representable in c_top comparisons.
    always_comb begin
        w_q_ext  = {1'b0, q};
        w_sum    = w_q_ext;
        at_limit = 1'b0;
        if (en) begin
            if (up) begin
                if (w_q_ext == c_top) begin
                    at_limit = 1'b1;
                    w_sum    = (SATURATE == CNT_SAT) ? w_q_ext : '0;
                end else begin
                    w_sum = w_q_ext + c_one;
                end
            end else begin
                if (w_q_ext == '0) begin
                    at_limit = 1'b1;
                    w_sum    = (SATURATE == CNT_SAT) ? w_q_ext : c_top;
                end else begin
                    w_sum = w_q_ext - c_one;
                end
            end
        end
    end

    assign next_q       = w_sum[WIDTH-1:0];
    assign w_unused_msb = w_sum[WIDTH];

endmodule
`default_nettype wire

// File: rtl/prog_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : prog_updown_counter
// Description : Parametrised synchronous up/down modulo counter with load,
//               clear, wrap/saturate mode, terminal-count pulse and sticky ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_updown_counter
    import cnt_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    generate
        if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
            $error("prog_updown_counter: WIDTH must be 1..32");
        end
        if ((MODULUS < 2) || (MODULUS > (longint'(1) << WIDTH))) begin : g_bad_modulus
            $error("prog_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next_q;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_load_q;

    assign w_load_q = WIDTH'(clamp_load(33'(load_val), 33'(MODULUS)));

    cnt_limit_detect #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_limit (
        .q        (r_q),
        .up       (up),
        .en       (en),
        .at_limit (w_at_limit),
        .next_q   (w_next_q)
    );

    // Priority: clr > load > en > hold; tc is a pulse, so every non-limit edge clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_q;
            r_tc  <= 1'b0;
        end else if (en) begin
            r_q   <= w_next_q;
            r_tc  <= w_at_limit;
            if (w_at_limit) begin
                r_ovf <= 1'b1;
            end
        end else begin
            r_tc  <= 1'b0;
        end
    end

    assign q   = r_q;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_prog_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_updown_counter
// Description : Directed self-checking bench for three counter configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_updown_counter;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic [2:0] load_val_b;
    logic       en;
    logic       up;

    logic [3:0] a_q;
    logic       a_tc, a_ovf;
    logic [3:0] s_q;
    logic       s_tc, s_ovf;
    logic [2:0] b_q;
    logic       b_tc, b_ovf;

    int total;
    int bad;

    // a: mod-10 wrap, s: mod-10 saturate, b: 3-bit full-range wrap
    prog_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_a (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(a_q), .tc(a_tc), .ovf(a_ovf));

    prog_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(s_q), .tc(s_tc), .ovf(s_ovf));

    prog_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val_b),
        .en(en), .up(up), .q(b_q), .tc(b_tc), .ovf(b_ovf));

    assign load_val_b = load_val[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        en       = 1'b1;
        up       = 1'b1;

        // Reset held across an enabled edge
        #2;
        chk("rst_q", 32'(a_q), 32'd0);
        step();
        chk("rst_hold_q", 32'(a_q), 32'd0);
        chk("rst_hold_tc", 32'(a_tc), 32'd0);
        chk("rst_hold_ovf", 32'(a_ovf), 32'd0);
        en = 1'b0;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_q", 32'(a_q), 32'd0);
            chk("idle_tc", 32'(a_tc), 32'd0);
            chk("idle_ovf", 32'(a_ovf), 32'd0);
        end

        // Count up 10 cycles
        en = 1'b1;
        up = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk("up_a_q", 32'(a_q), 32'(i % 10));
            chk("up_a_tc", 32'(a_tc), 32'(i == 10));
            chk("up_a_ovf", 32'(a_ovf), 32'(i == 10));
            chk("up_b_q", 32'(b_q), 32'(i % 8));
            chk("up_b_tc", 32'(b_tc), 32'(i == 8));
            chk("up_s_q", 32'(s_q), 32'((i < 9) ? i : 9));
            chk("up_s_tc", 32'(s_tc), 32'(i == 10));
        end

        // Down from 0 wraps to 9, then plain decrements
        up = 1'b0;
        step();
        chk("dn_wrap_q", 32'(a_q), 32'd9);
        chk("dn_wrap_tc", 32'(a_tc), 32'd1);
        for (int i = 8; i >= 6; i--) begin
            step();
            chk("dn_q", 32'(a_q), 32'(i));
            chk("dn_tc", 32'(a_tc), 32'd0);
        end

        // clr beats load and en
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 4'd5;
        en       = 1'b1;
        step();
        chk("clr_a_q", 32'(a_q), 32'd0);
        chk("clr_a_ovf", 32'(a_ovf), 32'd0);
        chk("clr_a_tc", 32'(a_tc), 32'd0);
        chk("clr_s_q", 32'(s_q), 32'd0);
        chk("clr_s_ovf", 32'(s_ovf), 32'd0);

        // Out-of-range load clamps to MODULUS-1; load beats en
        clr      = 1'b0;
        load_val = 4'd12;
        step();
        chk("clamp_a_q", 32'(a_q), 32'd9);
        chk("clamp_s_q", 32'(s_q), 32'd9);
        chk("load_b_q", 32'(b_q), 32'd4);
        chk("load_tc", 32'(a_tc), 32'd0);

        // Saturating count from 7
        load_val = 4'd7;
        step();
        chk("ld7_s_q", 32'(s_q), 32'd7);
        chk("ld7_s_ovf", 32'(s_ovf), 32'd0);
        load = 1'b0;
        up   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("sat_s_q", 32'(s_q), 32'((i < 2) ? 7 + i : 9));
            chk("sat_s_tc", 32'(s_tc), 32'(i >= 3));
            chk("sat_s_ovf", 32'(s_ovf), 32'(i >= 3));
            chk("sat_a_q", 32'(a_q), 32'((7 + i) % 10));
        end

        // en low holds q and ovf, clears tc
        en = 1'b0;
        step();
        chk("hold_s_q", 32'(s_q), 32'd9);
        chk("hold_s_tc", 32'(s_tc), 32'd0);
        chk("hold_s_ovf", 32'(s_ovf), 32'd1);

        // Asynchronous reset between edges
        load     = 1'b1;
        load_val = 4'd5;
        step();
        chk("pre_rst_q", 32'(a_q), 32'd5);
        load = 1'b0;
        en   = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_q", 32'(a_q), 32'd0);
        chk("async_rst_ovf", 32'(s_ovf), 32'd0);
        step();
        chk("async_hold_q", 32'(a_q), 32'd0);
        #2;
        reset = 1'b0;

        // Full-range 3-bit counter natural rollover
        en       = 1'b0;
        load     = 1'b1;
        load_val = 4'd7;
        step();
        chk("b_ld7_q", 32'(b_q), 32'd7);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        step();
        chk("b_roll_q", 32'(b_q), 32'd0);
        chk("b_roll_tc", 32'(b_tc), 32'd1);
        chk("b_roll_ovf", 32'(b_ovf), 32'd1);
        step();
        chk("b_after_q", 32'(b_q), 32'd1);
        chk("b_after_tc", 32'(b_tc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
